// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - op codes, FSM encoding, PSR bit indices and decode helpers for alu_issue_ctrl
package cpu_pkg;

    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_LSH = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_LUI = 4'b1111;

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // LUI only makes sense with an immediate byte to place in the upper half
    function automatic logic is_legal(input logic [3:0] op, input logic imm);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_LSH,
            OP_ADD, OP_SUB, OP_CMP, OP_MOV: is_legal = 1'b1;
            OP_LUI:                         is_legal = imm;
            default:                        is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic updates_flags(input logic [3:0] op);
        updates_flags = (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

    // CMP only produces flags; illegal instructions never touch the register file
    function automatic logic writes_back(input logic [3:0] op, input logic legal);
        writes_back = legal && (op != OP_CMP);
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 16-entry register file, one sync write port, two operand reads and one debug read
module reg_file
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr_a,
    input  logic [3:0]        raddr_b,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // single write port, whole array cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - non-pipelined instruction issue/writeback sequencer for the 16-bit ALU (option: FAST_ISSUE_EN)
module alu_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic              done,
    output logic              illegal,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_imm,
    output logic              alu_carry_in,
    output logic              alu_update_flags,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_low,
    input  logic              alu_flag,
    input  logic              alu_zero,
    input  logic              alu_negative,
    output logic [4:0]        psr,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    state_t            next_state;

    logic [15:0]       instr_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] res_q;
    logic [4:0]        flags_q;
    logic [4:0]        psr_q;

    logic              accept;
    logic              load_ops;
    logic              exec_latch;
    logic              rf_we;
    logic              psr_we;

    // decode of the instruction currently in flight
    logic              cur_reg_form;
    logic [3:0]        cur_op;
    logic              cur_legal;

    assign cur_reg_form = (instr_q[15:12] == 4'h0);
    assign cur_op       = cur_reg_form ? instr_q[7:4] : instr_q[15:12];
    assign cur_legal    = is_legal(cur_op, !cur_reg_form);

    // word that addresses the operand reads: the incoming instruction when
    // operands are fetched in the accept cycle, otherwise the latched one
    logic [15:0]       rd_word;
    logic              rd_reg_form;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

`ifdef FAST_ISSUE_EN
    assign rd_word = instr;
`else
    assign rd_word = instr_q;
`endif
    assign rd_reg_form = (rd_word[15:12] == 4'h0);

    reg_file #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_reg_file (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (instr_q[11:8]),
        .wdata    (res_q),
        .raddr_a  (rd_word[11:8]),
        .raddr_b  (rd_word[3:0]),
        .dbg_addr (dbg_addr),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .dbg_data (dbg_data)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state and per-state strobes
    always_comb begin
        next_state       = state;
        instr_ready      = 1'b0;
        done             = 1'b0;
        illegal          = 1'b0;
        alu_update_flags = 1'b0;
        accept           = 1'b0;
        load_ops         = 1'b0;
        exec_latch       = 1'b0;
        rf_we            = 1'b0;
        psr_we           = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept = 1'b1;
`ifdef FAST_ISSUE_EN
                    load_ops   = 1'b1;
                    next_state = ST_EXEC;
`else
                    next_state = ST_READ;
`endif
                end
            end
            ST_READ: begin
                load_ops   = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                alu_update_flags = cur_legal && updates_flags(cur_op);
                exec_latch       = 1'b1;
                next_state       = ST_WB;
            end
            ST_WB: begin
                done       = 1'b1;
                illegal    = !cur_legal;
                rf_we      = writes_back(cur_op, cur_legal);
                psr_we     = cur_legal && updates_flags(cur_op);
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // instruction, operand, result and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            psr_q   <= '0;
        end else begin
            if (accept) begin
                instr_q <= instr;
            end
            if (load_ops) begin
                op_a <= rdata_a;
                op_b <= rd_reg_form ? rdata_b : {{(DATA_W-8){1'b0}}, rd_word[7:0]};
            end
            if (exec_latch) begin
                res_q          <= alu_result;
                flags_q[PSR_C] <= alu_carry;
                flags_q[PSR_L] <= alu_low;
                flags_q[PSR_F] <= alu_flag;
                flags_q[PSR_Z] <= alu_zero;
                flags_q[PSR_N] <= alu_negative;
            end
            if (psr_we) begin
                psr_q <= flags_q;
            end
        end
    end

    assign alu_a        = op_a;
    assign alu_b        = op_b;
    assign alu_op       = cur_op;
    assign alu_imm      = !cur_reg_form;
    assign alu_carry_in = psr_q[PSR_C];
    assign psr          = psr_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with ALU model and instruction-level reference
module tb_alu_issue_ctrl;

`ifdef FAST_ISSUE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0000;
    logic        done;
    logic        illegal;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_imm;
    logic        alu_carry_in;
    logic        alu_update_flags;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        alu_low;
    logic        alu_flag;
    logic        alu_zero;
    logic        alu_negative;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr = 4'h0;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .done             (done),
        .illegal          (illegal),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_op           (alu_op),
        .alu_imm          (alu_imm),
        .alu_carry_in     (alu_carry_in),
        .alu_update_flags (alu_update_flags),
        .alu_result       (alu_result),
        .alu_carry        (alu_carry),
        .alu_low          (alu_low),
        .alu_flag         (alu_flag),
        .alu_zero         (alu_zero),
        .alu_negative     (alu_negative),
        .psr              (psr),
        .dbg_addr         (dbg_addr),
        .dbg_data         (dbg_data)
    );

    always #5 clk = ~clk;

    // ALU behaviour: returns {result, C, L, F, Z, N}; arithmetic immediates are sign-extended
    function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op, input logic imm);
        logic [15:0] bx;
        logic [15:0] r;
        logic [16:0] w;
        logic c, l, f, z, n;
        bx = (imm && (op == 4'h5 || op == 4'h9 || op == 4'hB || op == 4'hD))
             ? {{8{b[7]}}, b[7:0]} : b;
        r = 16'h0; c = 1'b0; l = 1'b0; f = 1'b0;
        case (op)
            4'h5: begin w = {1'b0, a} + {1'b0, bx}; r = w[15:0]; c = w[16];
                        f = (a[15] == bx[15]) && (r[15] != a[15]); end
            4'h9: begin r = a - bx; c = (a < bx); f = (a[15] != bx[15]) && (r[15] != a[15]); end
            4'hB: begin r = a - bx; l = (a < bx); end
            4'h1: r = a & bx;
            4'h2: r = a | bx;
            4'h3: r = a ^ bx;
            4'h4: r = a << bx[3:0];
            4'hD: r = bx;
            4'hF: r = {b[7:0], 8'h00};
            default: r = 16'h0;
        endcase
        z = (op == 4'hB) ? (a == bx) : (r == 16'h0);
        n = (op == 4'hB) ? ($signed(a) < $signed(bx)) : r[15];
        return {r, c, l, f, z, n};
    endfunction

    always_comb begin
        {alu_result, alu_carry, alu_low, alu_flag, alu_zero, alu_negative} =
            alu_fn(alu_a, alu_b, alu_op, alu_imm);
    end

    // instruction-level view of the architecture
    function automatic logic [3:0] w_op(input logic [15:0] w);
        return (w[15:12] == 4'h0) ? w[7:4] : w[15:12];
    endfunction

    function automatic logic w_legal(input logic [15:0] w);
        logic [3:0] op;
        op = w_op(w);
        if (op == 4'hF) return (w[15:12] != 4'h0);
        return (op == 4'h5 || op == 4'h9 || op == 4'h1 || op == 4'h2 || op == 4'h3 ||
                op == 4'hB || op == 4'h4 || op == 4'hD);
    endfunction

    function automatic logic w_flags(input logic [15:0] w);
        logic [3:0] op;
        op = w_op(w);
        return w_legal(w) && (op == 4'h5 || op == 4'h9 || op == 4'hB);
    endfunction

    logic [15:0] m_regs [16];
    logic [4:0]  m_psr = 5'h00;
    logic [15:0] m_instr = 16'h0000;
    int          m_cnt = 0;
    logic        started = 1'b0;

    function automatic logic [15:0] m_opb(input logic [15:0] w);
        return (w[15:12] == 4'h0) ? m_regs[w[3:0]] : {8'h00, w[7:0]};
    endfunction

    // reference: counts cycles since accept, retires the instruction LAT cycles later
    always @(posedge clk) begin
        logic [20:0] rv;
        started = 1'b1;
        if (reset) begin
            m_cnt = 0;
            m_psr = 5'h00;
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        end else if (m_cnt == 0) begin
            if (instr_valid) begin
                m_instr = instr;
                m_cnt = 1;
            end
        end else if (m_cnt == LAT) begin
            rv = alu_fn(m_regs[m_instr[11:8]], m_opb(m_instr), w_op(m_instr), m_instr[15:12] != 4'h0);
            if (w_legal(m_instr) && w_op(m_instr) != 4'hB) m_regs[m_instr[11:8]] = rv[20:5];
            if (w_flags(m_instr)) m_psr = rv[4:0];
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the reference
    always @(negedge clk) begin
        if (started) begin
            chk("instr_ready", 32'(instr_ready), 32'(m_cnt == 0));
            chk("done", 32'(done), 32'(m_cnt == LAT));
            chk("illegal", 32'(illegal), 32'((m_cnt == LAT) && !w_legal(m_instr)));
            chk("psr", 32'(psr), 32'(m_psr));
            chk("alu_carry_in", 32'(alu_carry_in), 32'(m_psr[4]));
            chk("alu_update_flags", 32'(alu_update_flags),
                32'((m_cnt == LAT - 1) && w_flags(m_instr)));
            chk("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_addr]));
            if (m_cnt == LAT - 1) begin
                chk("alu_a", 32'(alu_a), 32'(m_regs[m_instr[11:8]]));
                chk("alu_b", 32'(alu_b), 32'(m_opb(m_instr)));
                chk("alu_op", 32'(alu_op), 32'(w_op(m_instr)));
                chk("alu_imm", 32'(alu_imm), 32'(m_instr[15:12] != 4'h0));
            end
        end
    end

    // sweep the debug port so every register is compared repeatedly
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dbg_addr = dbg_addr + 4'h1;
        end
    end

    task automatic issue(input logic [15:0] w);
        @(posedge clk); #1;
        instr_valid = 1'b1;
        instr = w;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        repeat (LAT) @(posedge clk);
    endtask

    localparam logic [15:0] VEC [12] = '{
        16'h0193, 16'h0241, 16'h0111, 16'h01F2, 16'h02B2, 16'h3305,
        16'h93FF, 16'h1FFF, 16'h2E80, 16'h4304, 16'h0131, 16'h0E5E
    };

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("lit_reset_psr", 32'(psr), 32'h00);
        chk("lit_reset_ready", 32'(instr_ready), 32'h1);

        issue(16'hD105);
        @(negedge clk);
        chk("lit_mov_r1", 32'(m_regs[1]), 32'h0005);
        chk("lit_mov_psr", 32'(psr), 32'h00);
        issue(16'h51FF);
        @(negedge clk);
        chk("lit_addi_r1", 32'(m_regs[1]), 32'h0004);
        chk("lit_addi_psr", 32'(psr), 32'h10);
        issue(16'hB104);
        @(negedge clk);
        chk("lit_cmpi_r1", 32'(m_regs[1]), 32'h0004);
        chk("lit_cmpi_psr", 32'(psr), 32'h02);
        issue(16'hF2AB);
        @(negedge clk);
        chk("lit_lui_r2", 32'(m_regs[2]), 32'hAB00);
        chk("lit_lui_psr", 32'(psr), 32'h02);
        issue(16'h0152);
        @(negedge clk);
        chk("lit_add_r1", 32'(m_regs[1]), 32'hAB04);
        chk("lit_add_psr", 32'(psr), 32'h01);
        issue(16'h7000);
        @(negedge clk);
        chk("lit_illegal_psr", 32'(psr), 32'h01);

        for (int i = 0; i < 12; i++) issue(VEC[i]);

        // valid held high: one accept per LAT+1 cycles, busy-cycle offers ignored
        @(posedge clk); #1;
        instr_valid = 1'b1;
        instr = 16'h5701;
        repeat (3 * (LAT + 1) + 1) @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (LAT + 1) @(posedge clk);

        // reset while the instruction sits in EXEC
        @(posedge clk); #1;
        instr_valid = 1'b1;
        instr = 16'hD1FF;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (LAT - 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("lit_abort_ready", 32'(instr_ready), 32'h1);
        chk("lit_abort_r1", 32'(m_regs[1]), 32'h0000);
        repeat (4) @(posedge clk);

        issue(16'hD105);
        @(negedge clk);
        chk("lit_after_abort_r1", 32'(m_regs[1]), 32'h0005);
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
